// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared constants and types for the 32x32 register file.
//   RF_DATA_WIDTH / RF_ADDR_WIDTH / RF_DEPTH : default geometry
//   RF_ZERO_ADDR                            : the hardwired-zero register
//   rf_data_t / rf_addr_t                   : word and address types
// -----------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DEPTH      = 32;

    localparam logic [RF_ADDR_WIDTH-1:0] RF_ZERO_ADDR = 5'd0;

    typedef logic [RF_DATA_WIDTH-1:0] rf_data_t;
    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;

endpackage : rf_pkg

// File: rtl/rf_word_reg.sv
// -----------------------------------------------------------------------------
// rf_word_reg
// One storage word of the register file: a register with a load enable and an
// asynchronous active-low clear.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear (word goes to zero)
//   load  : when 1, capture d at the next rising edge
//   d     : data in
//   q     : stored word
// -----------------------------------------------------------------------------
module rf_word_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : rf_word_reg

// File: rtl/register_file_32x32.sv
// -----------------------------------------------------------------------------
// register_file_32x32
// Register file between the ALU result bus and the ALU operand inputs.
// Two read ports with registered outputs, one write port, register 0 reads as
// zero and ignores writes.
//
// Optional feature (macro RF_WRITE_BYPASS_EN):
//   defined   : a read that hits the address being written on the same edge
//               returns the new write data (forwarding).
//   undefined : the same read returns the old stored value (read-before-write).
//   Storage behaviour is identical in both builds.
//
// Ports:
//   CLK     : rising-edge clock
//   RST     : asynchronous active-low reset (clears storage and read outputs)
//   READ    : capture both read ports into DATA_R1/DATA_R2 at the next edge
//   WRITE   : write DATA_W to ADDR_W at the next edge
//   ADDR_R1 : read port 1 address
//   ADDR_R2 : read port 2 address
//   ADDR_W  : write address
//   DATA_W  : write data
//   DATA_R1 : registered read data, port 1
//   DATA_R2 : registered read data, port 2
// -----------------------------------------------------------------------------
module register_file_32x32
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(RF_ZERO_ADDR);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_1;
    logic [DATA_WIDTH-1:0] rd_data_2;

    // Register 0 is a constant, so there is no flop to disturb on a write to it.
    assign mem[0] = '0;

    for (genvar i = 1; i < DEPTH; i++) begin : g_word
        logic load;
        assign load = WRITE & (ADDR_W == ADDR_WIDTH'(i));

        rf_word_reg #(
            .WIDTH (DATA_WIDTH)
        ) u_word (
            .clk   (CLK),
            .rst_n (RST),
            .load  (load),
            .d     (DATA_W),
            .q     (mem[i])
        );
    end

    // Read muxes. Address 0 always yields mem[0] = 0; the bypass compare
    // excludes the zero address so forwarding can never leak write data there.
    always_comb begin
        rd_data_1 = mem[ADDR_R1];
        rd_data_2 = mem[ADDR_R2];
`ifdef RF_WRITE_BYPASS_EN
        if (WRITE && (ADDR_W != ZERO_ADDR)) begin
            if (ADDR_R1 == ADDR_W) begin
                rd_data_1 = DATA_W;
            end
            if (ADDR_R2 == ADDR_W) begin
                rd_data_2 = DATA_W;
            end
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            DATA_R1 <= '0;
            DATA_R2 <= '0;
        end else if (READ) begin
            DATA_R1 <= rd_data_1;
            DATA_R2 <= rd_data_2;
        end
    end

endmodule : register_file_32x32

// File: tb/tb_register_file_32x32.sv
// -----------------------------------------------------------------------------
// tb_register_file_32x32
// Directed self-checking bench for register_file_32x32. Expected values are
// hand-computed constants; the same-edge collision expectation follows the
// RF_WRITE_BYPASS_EN build option.
// -----------------------------------------------------------------------------
module tb_register_file_32x32;

    import rf_pkg::*;

    // ---------------------------------------------------------------- clock/reset
    logic     CLK;
    logic     RST;
    logic     READ;
    logic     WRITE;
    rf_addr_t ADDR_R1;
    rf_addr_t ADDR_R2;
    rf_addr_t ADDR_W;
    rf_data_t DATA_W;
    rf_data_t DATA_R1;
    rf_data_t DATA_R2;

    int n_checks = 0;
    int n_fail   = 0;

    rf_data_t exp_q[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    register_file_32x32 #(
        .DATA_WIDTH (RF_DATA_WIDTH),
        .ADDR_WIDTH (RF_ADDR_WIDTH)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .READ    (READ),
        .WRITE   (WRITE),
        .ADDR_R1 (ADDR_R1),
        .ADDR_R2 (ADDR_R2),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DATA_R1 (DATA_R1),
        .DATA_R2 (DATA_R2)
    );

    // ---------------------------------------------------------------- checker
    task automatic check_eq(input string tag, input rf_data_t obs, input rf_data_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------- drivers
    // Inputs change on the falling edge; outputs are sampled on the falling
    // edge that follows the active rising edge.
    task automatic write_word(input rf_addr_t a, input rf_data_t d);
        @(negedge CLK);
        WRITE  = 1'b1;
        ADDR_W = a;
        DATA_W = d;
        @(negedge CLK);
        WRITE  = 1'b0;
    endtask

    task automatic read_pair(input rf_addr_t a1, input rf_addr_t a2);
        @(negedge CLK);
        READ    = 1'b1;
        ADDR_R1 = a1;
        ADDR_R2 = a2;
        @(negedge CLK);
        READ    = 1'b0;
    endtask

    // Read and write on the same rising edge.
    task automatic read_write(input rf_addr_t ra, input rf_addr_t wa, input rf_data_t d);
        @(negedge CLK);
        READ    = 1'b1;
        WRITE   = 1'b1;
        ADDR_R1 = ra;
        ADDR_R2 = ra;
        ADDR_W  = wa;
        DATA_W  = d;
        @(negedge CLK);
        READ    = 1'b0;
        WRITE   = 1'b0;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        rf_data_t old_val;
        rf_data_t new_val;

        RST     = 1'b0;
        READ    = 1'b0;
        WRITE   = 1'b0;
        ADDR_R1 = '0;
        ADDR_R2 = '0;
        ADDR_W  = '0;
        DATA_W  = '0;

        #1;
        check_eq("reset_r1", DATA_R1, 32'h0000_0000);
        check_eq("reset_r2", DATA_R2, 32'h0000_0000);
        @(negedge CLK);
        RST = 1'b1;

        // Asynchronous reset mid-run.
        write_word(5'd5, 32'hDEAD_BEEF);
        read_pair(5'd5, 5'd5);
        check_eq("pre_rst_r1", DATA_R1, 32'hDEAD_BEEF);
        check_eq("pre_rst_r2", DATA_R2, 32'hDEAD_BEEF);
        #1;
        RST = 1'b0;
        #1;
        check_eq("async_rst_r1", DATA_R1, 32'h0000_0000);
        check_eq("async_rst_r2", DATA_R2, 32'h0000_0000);
        #2;
        RST = 1'b1;
        read_pair(5'd5, 5'd0);
        check_eq("post_rst_mem5", DATA_R1, 32'h0000_0000);
        check_eq("post_rst_mem0", DATA_R2, 32'h0000_0000);

        // Zero register ignores writes.
        write_word(5'd0, 32'hFFFF_FFFF);
        read_pair(5'd0, 5'd0);
        check_eq("zero_r1", DATA_R1, 32'h0000_0000);
        check_eq("zero_r2", DATA_R2, 32'h0000_0000);

        // Basic write/read.
        write_word(5'd1, 32'hFFFF_FFFF);
        write_word(5'd2, 32'h0000_0000);
        read_pair(5'd1, 5'd2);
        check_eq("basic_r1", DATA_R1, 32'hFFFF_FFFF);
        check_eq("basic_r2", DATA_R2, 32'h0000_0000);

        // Hold with READ low.
        @(negedge CLK);
        ADDR_R1 = 5'd2;
        @(negedge CLK);
        @(negedge CLK);
        check_eq("hold_r1", DATA_R1, 32'hFFFF_FFFF);
        check_eq("hold_r2", DATA_R2, 32'h0000_0000);

        // Same-edge collision.
        old_val = 32'h1234_5678;
        new_val = 32'hA5A5_A5A5;
        write_word(5'd7, old_val);
        read_write(5'd7, 5'd7, new_val);
`ifdef RF_WRITE_BYPASS_EN
        check_eq("collide_r1", DATA_R1, new_val);
        check_eq("collide_r2", DATA_R2, new_val);
`else
        check_eq("collide_r1", DATA_R1, old_val);
        check_eq("collide_r2", DATA_R2, old_val);
`endif
        read_pair(5'd7, 5'd7);
        check_eq("after_collide_r1", DATA_R1, new_val);
        check_eq("after_collide_r2", DATA_R2, new_val);

        // Same-edge write to and read of address 0 never forwards.
        read_write(5'd0, 5'd0, 32'h5A5A_5A5A);
        check_eq("collide_zero_r1", DATA_R1, 32'h0000_0000);
        check_eq("collide_zero_r2", DATA_R2, 32'h0000_0000);

        // Sweep: mem[i] = i * 32'h01010101, read back pairs (i, 32-i).
        for (int i = 1; i < 32; i++) begin
            write_word(rf_addr_t'(i), rf_data_t'(i) * 32'h0101_0101);
        end
        for (int i = 0; i < 32; i++) begin
            int j;
            j = (32 - i) % 32;
            exp_q.push_back(rf_data_t'(i) * 32'h0101_0101);
            exp_q.push_back(rf_data_t'(j) * 32'h0101_0101);
            read_pair(rf_addr_t'(i), rf_addr_t'(j));
            check_eq($sformatf("sweep_r1_%0d", i), DATA_R1, exp_q.pop_front());
            check_eq($sformatf("sweep_r2_%0d", j), DATA_R2, exp_q.pop_front());
        end

        // ---------------------------------------------------------------- report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_register_file_32x32
